// File: rtl/cnn_pkg.sv
// Shared types for the CNN datapath: feeder FSM states and the default operand width.
package cnn_pkg;

  localparam int DEFAULT_DATA_W = 8;

  typedef logic [DEFAULT_DATA_W-1:0] data_t;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    OUT
  } pe_feeder_state_e;

endpackage

// File: rtl/pe_feeder_if.sv
// Feeder-side bundle: operand buffer read ports, PE MAC port and the result valid/ready port.
interface pe_feeder_if
  import cnn_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DATA_W = DEFAULT_DATA_W
) ();

  logic              ifm_rd_en;
  logic [ADDR_W-1:0] ifm_addr;
  logic [DATA_W-1:0] ifm_rd_data;
  logic              wgt_rd_en;
  logic [ADDR_W-1:0] wgt_addr;
  logic [DATA_W-1:0] wgt_rd_data;
  logic [DATA_W-1:0] pe_ifm;
  logic [DATA_W-1:0] pe_weight;
  logic              pe_en;
  logic              pe_finish;
  logic [DATA_W-1:0] pe_ofm;
  logic              pe_valid;
  logic [DATA_W-1:0] ofm_data;
  logic              ofm_valid;
  logic              ofm_ready;

  modport master (
    output ifm_rd_en, ifm_addr, wgt_rd_en, wgt_addr,
    output pe_ifm, pe_weight, pe_en, pe_finish,
    output ofm_data, ofm_valid,
    input  ifm_rd_data, wgt_rd_data, pe_ofm, pe_valid, ofm_ready
  );

  modport slave (
    input  ifm_rd_en, ifm_addr, wgt_rd_en, wgt_addr,
    input  pe_ifm, pe_weight, pe_en, pe_finish,
    input  ofm_data, ofm_valid,
    output ifm_rd_data, wgt_rd_data, pe_ofm, pe_valid, ofm_ready
  );

endinterface

// File: rtl/pe.sv
// Single MAC processing element: en restarts the sum, finish returns it one cycle later with valid.
module pe
  import cnn_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] ifm,
  input  logic [DATA_W-1:0] weight,
  input  logic              en,
  input  logic              finish,
  output logic [DATA_W-1:0] ofm,
  output logic              valid
);

  logic [DATA_W-1:0] prod;
  logic [DATA_W-1:0] acc_q;
  logic              active_q;
  logic              valid_q;

  assign prod = ifm * weight;

  always_ff @(posedge clk) begin
    if (reset) begin
      acc_q    <= '0;
      active_q <= 1'b0;
      valid_q  <= 1'b0;
    end else begin
      valid_q <= finish;
      if (en) begin
        acc_q    <= prod;
        active_q <= !finish;
      end else if (active_q) begin
        acc_q    <= acc_q + prod;
        active_q <= !finish;
      end
    end
  end

  assign ofm   = acc_q;
  assign valid = valid_q;

endmodule

// File: rtl/pe_addr_gen.sv
// Term/output counters for the feeder; addresses are formed from latched bases and wrap naturally.
module pe_addr_gen
  import cnn_pkg::*;
#(
  parameter int K_LEN  = 9,
  parameter int ADDR_W = 8,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic              step_k,
  input  logic              next_out,
  input  logic [ADDR_W-1:0] ifm_base,
  input  logic [ADDR_W-1:0] wgt_base,
  input  logic [CNT_W-1:0]  num_out,
  output logic [ADDR_W-1:0] ifm_addr,
  output logic [ADDR_W-1:0] wgt_addr,
  output logic              k_first,
  output logic              k_last,
  output logic              out_last
);

  localparam logic [ADDR_W-1:0] K_STEP = ADDR_W'(K_LEN);
  localparam logic [ADDR_W-1:0] K_MAX  = ADDR_W'(K_LEN - 1);
  localparam logic [ADDR_W-1:0] ONE_A  = ADDR_W'(1);
  localparam logic [CNT_W-1:0]  ONE_C  = CNT_W'(1);

  logic [ADDR_W-1:0] ifm_base_q;
  logic [ADDR_W-1:0] wgt_base_q;
  logic [ADDR_W-1:0] row_q;
  logic [ADDR_W-1:0] k_q;
  logic [CNT_W-1:0]  num_q;
  logic [CNT_W-1:0]  out_idx_q;

  // row_q tracks out_idx*K_LEN incrementally so no multiplier is needed.
  always_ff @(posedge clk) begin
    if (reset) begin
      ifm_base_q <= '0;
      wgt_base_q <= '0;
      row_q      <= '0;
      k_q        <= '0;
      num_q      <= '0;
      out_idx_q  <= '0;
    end else if (load) begin
      ifm_base_q <= ifm_base;
      wgt_base_q <= wgt_base;
      num_q      <= num_out;
      row_q      <= '0;
      k_q        <= '0;
      out_idx_q  <= '0;
    end else begin
      if (step_k) begin
        k_q <= k_last ? '0 : k_q + ONE_A;
      end
      if (next_out) begin
        out_idx_q <= out_idx_q + ONE_C;
        row_q     <= row_q + K_STEP;
        k_q       <= '0;
      end
    end
  end

  assign ifm_addr = ifm_base_q + row_q + k_q;
  assign wgt_addr = wgt_base_q + k_q;
  assign k_first  = (k_q == '0);
  assign k_last   = (k_q == K_MAX);
  assign out_last = (out_idx_q == num_q - ONE_C);

endmodule

// File: rtl/pe_feeder.sv
// Streams IFM/weight pairs from 1-cycle buffers into one PE and returns each result on valid/ready.
module pe_feeder
  import cnn_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W,
  parameter int K_LEN  = 9,
  parameter int ADDR_W = 8,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] ifm_base,
  input  logic [ADDR_W-1:0] wgt_base,
  input  logic [CNT_W-1:0]  num_out,
  output logic              busy,
  output logic              done,
  pe_feeder_if.master       bus
);

  pe_feeder_state_e state_q, state_d;

  logic              rd_en, load, zero_job, capture, xfer, next_out;
  logic              k_first, k_last, out_last;
  logic              pe_en_q, pe_finish_q, done_q, ofm_valid_q;
  logic [DATA_W-1:0] ofm_data_q;

  pe_addr_gen #(
    .K_LEN  (K_LEN),
    .ADDR_W (ADDR_W),
    .CNT_W  (CNT_W)
  ) u_addr_gen (
    .clk      (clk),
    .reset    (reset),
    .load     (load),
    .step_k   (rd_en),
    .next_out (next_out),
    .ifm_base (ifm_base),
    .wgt_base (wgt_base),
    .num_out  (num_out),
    .ifm_addr (bus.ifm_addr),
    .wgt_addr (bus.wgt_addr),
    .k_first  (k_first),
    .k_last   (k_last),
    .out_last (out_last)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start && num_out != '0) state_d = ISSUE;
      ISSUE:   if (k_last) state_d = WAIT;
      WAIT:    if (bus.pe_valid) state_d = OUT;
      OUT:     if (xfer) state_d = out_last ? IDLE : ISSUE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    rd_en    = 1'b0;
    load     = 1'b0;
    zero_job = 1'b0;
    capture  = 1'b0;
    xfer     = 1'b0;
    unique case (state_q)
      IDLE: begin
        load     = start && (num_out != '0);
        zero_job = start && (num_out == '0);
      end
      ISSUE:   rd_en   = 1'b1;
      WAIT:    capture = bus.pe_valid;
      OUT:     xfer    = ofm_valid_q && bus.ofm_ready;
      default: ;
    endcase
  end

  assign next_out = xfer && !out_last;

  // PE controls are delayed one cycle so they line up with the buffer read data.
  always_ff @(posedge clk) begin
    if (reset) begin
      pe_en_q     <= 1'b0;
      pe_finish_q <= 1'b0;
      done_q      <= 1'b0;
      ofm_valid_q <= 1'b0;
      ofm_data_q  <= '0;
    end else begin
      pe_en_q     <= rd_en && k_first;
      pe_finish_q <= rd_en && k_last;
      done_q      <= zero_job || (xfer && out_last);
      if (capture) begin
        ofm_data_q  <= bus.pe_ofm;
        ofm_valid_q <= 1'b1;
      end else if (xfer) begin
        ofm_valid_q <= 1'b0;
      end
    end
  end

  assign busy          = (state_q != IDLE);
  assign done          = done_q;
  assign bus.ifm_rd_en = rd_en;
  assign bus.wgt_rd_en = rd_en;
  assign bus.pe_ifm    = bus.ifm_rd_data;
  assign bus.pe_weight = bus.wgt_rd_data;
  assign bus.pe_en     = pe_en_q;
  assign bus.pe_finish = pe_finish_q;
  assign bus.ofm_data  = ofm_data_q;
  assign bus.ofm_valid = ofm_valid_q;

endmodule

// File: tb/tb_pe_feeder.sv
// Drives two feeders (K_LEN=3 and K_LEN=1) into real PEs and checks them against a dot-product model.
module tb_pe_feeder;
  import cnn_pkg::*;

  localparam int AW = 8;
  localparam int DW = 8;
  localparam int CW = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset;
  logic          start3, start1;
  logic [AW-1:0] ib, wb;
  logic [CW-1:0] num;
  logic          ready;
  logic          busy3, done3, busy1, done1;
  int            sel;
  int            total = 0;
  int            bad   = 0;

  data_t ifm_mem [256];
  data_t wgt_mem [256];

  pe_feeder_if #(.ADDR_W(AW), .DATA_W(DW)) b3 ();
  pe_feeder_if #(.ADDR_W(AW), .DATA_W(DW)) b1 ();

  pe_feeder #(.DATA_W(DW), .K_LEN(3), .ADDR_W(AW), .CNT_W(CW)) dut3 (
    .clk(clk), .reset(reset), .start(start3), .ifm_base(ib), .wgt_base(wb),
    .num_out(num), .busy(busy3), .done(done3), .bus(b3.master)
  );
  pe #(.DATA_W(DW)) pe3 (
    .clk(clk), .reset(reset), .ifm(b3.pe_ifm), .weight(b3.pe_weight),
    .en(b3.pe_en), .finish(b3.pe_finish), .ofm(b3.pe_ofm), .valid(b3.pe_valid)
  );

  pe_feeder #(.DATA_W(DW), .K_LEN(1), .ADDR_W(AW), .CNT_W(CW)) dut1 (
    .clk(clk), .reset(reset), .start(start1), .ifm_base(ib), .wgt_base(wb),
    .num_out(num), .busy(busy1), .done(done1), .bus(b1.master)
  );
  pe #(.DATA_W(DW)) pe1 (
    .clk(clk), .reset(reset), .ifm(b1.pe_ifm), .weight(b1.pe_weight),
    .en(b1.pe_en), .finish(b1.pe_finish), .ofm(b1.pe_ofm), .valid(b1.pe_valid)
  );

  assign b3.ofm_ready = ready;
  assign b1.ofm_ready = ready;

  // Synchronous buffers with one cycle of read latency.
  always @(posedge clk) begin
    if (b3.ifm_rd_en) b3.ifm_rd_data <= ifm_mem[b3.ifm_addr];
    if (b3.wgt_rd_en) b3.wgt_rd_data <= wgt_mem[b3.wgt_addr];
    if (b1.ifm_rd_en) b1.ifm_rd_data <= ifm_mem[b1.ifm_addr];
    if (b1.wgt_rd_en) b1.wgt_rd_data <= wgt_mem[b1.wgt_addr];
  end

  logic          m_busy, m_done, m_ird, m_wrd, m_en, m_fin, m_ovld;
  logic [AW-1:0] m_iaddr, m_waddr;
  logic [DW-1:0] m_odat;

  assign m_busy  = (sel == 1) ? busy1 : busy3;
  assign m_done  = (sel == 1) ? done1 : done3;
  assign m_ird   = (sel == 1) ? b1.ifm_rd_en : b3.ifm_rd_en;
  assign m_wrd   = (sel == 1) ? b1.wgt_rd_en : b3.wgt_rd_en;
  assign m_en    = (sel == 1) ? b1.pe_en : b3.pe_en;
  assign m_fin   = (sel == 1) ? b1.pe_finish : b3.pe_finish;
  assign m_ovld  = (sel == 1) ? b1.ofm_valid : b3.ofm_valid;
  assign m_iaddr = (sel == 1) ? b1.ifm_addr : b3.ifm_addr;
  assign m_waddr = (sel == 1) ? b1.wgt_addr : b3.wgt_addr;
  assign m_odat  = (sel == 1) ? b1.ofm_data : b3.ofm_data;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_start(input int s, input logic v);
    if (s == 1) start1 = v;
    else        start3 = v;
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_busy"},   m_busy, 0);
    chk({tag, "_done"},   m_done, 0);
    chk({tag, "_rd"},     {m_ird, m_wrd}, 0);
    chk({tag, "_pe_ctl"}, {m_en, m_fin}, 0);
    chk({tag, "_ovld"},   m_ovld, 0);
    chk({tag, "_addr"},   {m_iaddr, m_waddr}, 0);
    chk({tag, "_odat"},   m_odat, 0);
  endtask

  // Runs one job; hold = cycles of ofm_ready low on the first result, poke = cycle to pulse a stray start.
  task automatic run_job(input int s, input logic [AW-1:0] ibase, input logic [AW-1:0] wbase,
                         input int n, input int hold, input int poke);
    int kl, cyc, budget, rd_n, xfers, hold_left;
    bit en_seen, fin_seen, val_seen, got_done;
    data_t exp_q[$];
    logic [AW-1:0] ea_q[$], ew_q[$];
    kl = (s == 1) ? 1 : 3;
    for (int o = 0; o < n; o++) begin
      int acc;
      acc = 0;
      for (int k = 0; k < kl; k++) begin
        int ia, wa;
        ia = (int'(ibase) + o * kl + k) % 256;
        wa = (int'(wbase) + k) % 256;
        ea_q.push_back(AW'(ia));
        ew_q.push_back(AW'(wa));
        acc += int'(ifm_mem[ia]) * int'(wgt_mem[wa]);
      end
      exp_q.push_back(data_t'(acc % 256));
    end
    sel = s; ib = ibase; wb = wbase; num = CW'(n); ready = 1'b1;
    set_start(s, 1'b1);
    tick();
    set_start(s, 1'b0);
    cyc = 1; rd_n = 0; xfers = 0; hold_left = hold;
    en_seen = 0; fin_seen = 0; val_seen = 0; got_done = 0;
    budget = n * (kl + 3 + hold) + 12;
    while (!got_done && cyc < budget) begin
      if (cyc == poke) begin
        set_start(s, 1'b1);
        ib = ~ibase; wb = ~wbase; num = CW'(7);
      end else begin
        set_start(s, 1'b0);
      end
      chk("rd_en_equal", m_wrd, m_ird);
      if (m_ird) begin
        if (rd_n < ea_q.size()) begin
          chk("ifm_addr", m_iaddr, ea_q[rd_n]);
          chk("wgt_addr", m_waddr, ew_q[rd_n]);
        end
        rd_n++;
      end
      if (m_en && !en_seen) begin
        en_seen = 1;
        chk("pe_en_cycle", cyc, 2);
      end
      if (m_fin && !fin_seen) begin
        fin_seen = 1;
        chk("pe_finish_cycle", cyc, kl + 1);
      end
      if (m_ovld) begin
        if (!val_seen) begin
          val_seen = 1;
          chk("ofm_valid_cycle", cyc, kl + 3);
        end
        if (xfers >= n) begin
          chk("extra_output", xfers, n - 1);
        end else if (hold_left > 0) begin
          ready = 1'b0;
          hold_left--;
          chk("hold_data", m_odat, exp_q[xfers]);
          chk("hold_no_read", m_ird, 0);
        end else begin
          ready = 1'b1;
          chk("ofm_data", m_odat, exp_q[xfers]);
          xfers++;
        end
      end else begin
        ready = 1'b1;
      end
      if (m_done) begin
        got_done = 1;
        chk("busy_at_done", m_busy, 0);
        chk("xfers_at_done", xfers, n);
      end
      tick();
      cyc++;
    end
    set_start(s, 1'b0);
    ready = 1'b1;
    chk("done_seen", got_done, 1);
    chk("done_single", m_done, 0);
    chk("read_count", rd_n, n * kl);
  endtask

  task automatic zero_job(input int s);
    sel = s; num = '0;
    set_start(s, 1'b1);
    tick();
    set_start(s, 1'b0);
    chk("zero_done", m_done, 1);
    chk("zero_busy", m_busy, 0);
    chk("zero_rd", m_ird, 0);
    tick();
    chk("zero_done_once", m_done, 0);
    chk("zero_rd_after", m_ird, 0);
  endtask

  initial begin
    reset = 1'b1; start3 = 1'b0; start1 = 1'b0; ready = 1'b1;
    ib = '0; wb = '0; num = '0; sel = 0;
    for (int i = 0; i < 256; i++) begin
      ifm_mem[i] = data_t'($urandom);
      wgt_mem[i] = data_t'($urandom);
    end
    repeat (3) tick();
    sel = 0; check_all_zero("rst3");
    sel = 1; check_all_zero("rst1");
    reset = 1'b0;
    tick();

    ifm_mem[0] = 8'd1; ifm_mem[1] = 8'd2; ifm_mem[2] = 8'd3;
    wgt_mem[0] = 8'd4; wgt_mem[1] = 8'd5; wgt_mem[2] = 8'd6;
    run_job(0, 8'd0, 8'd0, 1, 0, -1);
    chk("dot3_value", m_odat, 32);

    ifm_mem[0] = 8'd20; wgt_mem[0] = 8'd20;
    run_job(1, 8'd0, 8'd0, 1, 0, -1);
    chk("wrap_144", m_odat, 144);
    ifm_mem[0] = 8'd16; wgt_mem[0] = 8'd16;
    run_job(1, 8'd0, 8'd0, 1, 0, -1);
    chk("wrap_zero", m_odat, 0);

    for (int i = 0; i < 256; i++) begin
      ifm_mem[i] = data_t'($urandom);
      wgt_mem[i] = data_t'($urandom);
    end
    run_job(0, 8'd10, 8'd0, 2, 0, -1);
    run_job(0, 8'($urandom), 8'($urandom), 2, 5, -1);
    run_job(1, 8'($urandom), 8'($urandom), 1, 5, -1);

    zero_job(0);
    zero_job(1);

    run_job(0, 8'd40, 8'd60, 2, 0, 2);
    run_job(0, 8'd254, 8'd254, 1, 0, -1);

    sel = 0; ib = 8'd5; wb = 8'd7; num = 8'd2;
    start3 = 1'b1;
    tick();
    start3 = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    tick();
    check_all_zero("midrst");
    reset = 1'b0;
    for (int i = 0; i < 12; i++) begin
      chk("midrst_no_done", {m_done, m_ird}, 0);
      tick();
    end
    run_job(0, 8'd5, 8'd7, 2, 0, -1);

    for (int j = 0; j < 8; j++) begin
      run_job(int'($urandom_range(0, 1)), 8'($urandom), 8'($urandom),
              int'($urandom_range(1, 3)), int'($urandom_range(0, 3)), -1);
      repeat ($urandom_range(0, 2)) tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
